// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch FSM encoding and the NOP word
// that the fetch stage presents while nothing valid has been fetched.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP    = 32'h0000_0004;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_HOLD  = 3'd4
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem request, single-entry output
// buffer towards decode, redirect support with stale-response flushing.
//
// state | meaning
// IDLE  | post-reset bubble, no request
// REQ   | request for pc presented to imem
// WAIT  | request accepted, waiting for its response
// FLUSH | redirected while waiting; swallow the stale response
// HOLD  | fetched instruction presented to decode
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] instr_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc         <= word_align(RESET_PC);
      instr_q    <= NOP_INSTR;
      instr_pc_q <= '0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_REQ;
        ST_REQ: begin
          // a redirect replaces the address; the request is not accepted this cycle
          if (redirect_valid) begin
            pc <= word_align(redirect_pc);
          end else if (imem_req_ready) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (redirect_valid) begin
            pc    <= word_align(redirect_pc);
            state <= imem_rsp_valid ? ST_REQ : ST_FLUSH;
          end else if (imem_rsp_valid) begin
            instr_q    <= imem_rsp_data;
            instr_pc_q <= pc;
            pc         <= word_align(pc + PC_STEP);
            state      <= ST_HOLD;
          end
        end
        ST_FLUSH: begin
          if (redirect_valid) begin
            pc <= word_align(redirect_pc);
          end
          if (imem_rsp_valid) begin
            state <= ST_REQ;
          end
        end
        ST_HOLD: begin
          // redirect wins over if_ready: the held instruction is dropped
          if (redirect_valid) begin
            pc    <= word_align(redirect_pc);
            state <= ST_REQ;
          end else if (if_ready) begin
            state <= ST_REQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign imem_req_valid = (state == ST_REQ);
  assign imem_req_addr  = pc;
  assign if_valid       = (state == ST_HOLD);
  assign if_instr       = instr_q;
  assign if_pc          = instr_pc_q;
  assign if_pc_plus4    = instr_pc_q + PC_STEP;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: table-driven fetch sequence plus
// hand-written redirect, wrap and reset sequences; deliveries checked by a scoreboard.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    int          rdy_dly;
    int          lat;
    int          stall;
    logic [31:0] addr;
  } vec_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd7) ^ 32'hDEAD_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // delivery monitor: a handshake happens at the next rising edge
  always @(negedge clk) begin : monitor
    exp_t e;
    #2;
    if (rst_n && if_valid && if_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_delivery: got pc %h instr %h want none", if_pc, if_instr);
      end else begin
        e = exp_q.pop_front();
        check("deliver_pc", if_pc, e.pc);
        check("deliver_instr", if_instr, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic reset_checks(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    check({tag, "_if_instr"}, if_instr, NOP_INSTR);
    check({tag, "_if_pc"}, if_pc, 32'd0);
    check({tag, "_if_pc_plus4"}, if_pc_plus4, 32'd4);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req_valid) begin
      n_total++;
      $display("FAIL req_timeout: got no request want request within 20 cycles");
    end
  endtask

  task automatic accept(input logic [31:0] exp_addr);
    wait_req();
    check("req_addr", imem_req_addr, exp_addr);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    check("wait_no_req", 32'(imem_req_valid), 32'd0);
  endtask

  task automatic fetch_to_hold(input int rdy_dly, input int lat, input logic [31:0] exp_addr);
    wait_req();
    check("req_addr", imem_req_addr, exp_addr);
    repeat (rdy_dly) begin
      @(negedge clk);
      check("req_stall_valid", 32'(imem_req_valid), 32'd1);
      check("req_stall_addr", imem_req_addr, exp_addr);
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    check("wait_no_req", 32'(imem_req_valid), 32'd0);
    repeat (lat - 1) @(negedge clk);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = mem_word(exp_addr);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    check("hold_valid", 32'(if_valid), 32'd1);
    check("hold_pc", if_pc, exp_addr);
    check("hold_instr", if_instr, mem_word(exp_addr));
    check("hold_pc_plus4", if_pc_plus4, exp_addr + 32'd4);
  endtask

  task automatic release_hold(input int stall, input logic [31:0] exp_addr);
    repeat (stall) begin
      @(negedge clk);
      check("stall_valid", 32'(if_valid), 32'd1);
      check("stall_pc", if_pc, exp_addr);
      check("stall_instr", if_instr, mem_word(exp_addr));
      check("stall_no_req", 32'(imem_req_valid), 32'd0);
    end
    exp_q.push_back('{exp_addr, mem_word(exp_addr)});
    if_ready = 1'b1;
    @(negedge clk);
    if_ready = 1'b0;
    check("release_drop_valid", 32'(if_valid), 32'd0);
    check("release_req", 32'(imem_req_valid), 32'd1);
    check("release_sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic fetch_one(input int rdy_dly, input int lat, input int stall, input logic [31:0] a);
    fetch_to_hold(rdy_dly, lat, a);
    release_hold(stall, a);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{0, 1, 0, 32'h0000_0000};
    vecs[1] = '{0, 1, 0, 32'h0000_0004};
    vecs[2] = '{0, 1, 0, 32'h0000_0008};
    vecs[3] = '{2, 3, 5, 32'h0000_000C};
    vecs[4] = '{1, 2, 1, 32'h0000_0010};

    repeat (2) @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) fetch_one(vecs[i].rdy_dly, vecs[i].lat, vecs[i].stall, vecs[i].addr);

    // redirect in WAIT, stale response arrives two cycles later
    accept(32'h0000_0014);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    if_ready       = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("flush_no_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    check("flush_still_no_req", 32'(imem_req_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    check("flush_if_valid", 32'(if_valid), 32'd0);
    check("flush_next_req", 32'(imem_req_valid), 32'd1);
    check("flush_next_addr", imem_req_addr, 32'h0000_0100);
    if_ready = 1'b0;
    fetch_one(0, 1, 0, 32'h0000_0100);

    // redirect in WAIT together with the response
    accept(32'h0000_0104);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD1_BAD1;
    if_ready       = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    check("wait_rsp_redir_if_valid", 32'(if_valid), 32'd0);
    check("wait_rsp_redir_addr", imem_req_addr, 32'h0000_0040);
    if_ready = 1'b0;
    fetch_one(0, 1, 0, 32'h0000_0040);

    // redirect wins over if_ready in HOLD, low bits of target dropped
    fetch_to_hold(0, 1, 32'h0000_0044);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    if_ready       = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    check("hold_redir_if_valid", 32'(if_valid), 32'd0);
    check("hold_redir_req", 32'(imem_req_valid), 32'd1);
    check("hold_redir_addr", imem_req_addr, 32'h0000_0200);
    fetch_one(0, 1, 0, 32'h0000_0200);

    // redirect in REQ to the top word, then wrap to zero
    wait_req();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("req_redir_addr", imem_req_addr, 32'hFFFF_FFFC);
    fetch_to_hold(0, 1, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", if_pc_plus4, 32'h0000_0000);
    release_hold(0, 32'hFFFF_FFFC);
    check("wrap_next_addr", imem_req_addr, 32'h0000_0000);

    // reset while a request is outstanding
    accept(32'h0000_0000);
    rst_n = 1'b0;
    #1;
    reset_checks("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fetch_one(0, 1, 0, 32'h0000_0000);

    check("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, address of first fetch after reset.
REQ-002 SHALL have ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  fetch data valid, one cycle per accepted request.
- imem_rsp_data  in  32  fetched instruction word.
- redirect_valid  in  1  branch/jump taken, flush fetch.
- redirect_pc  in  32  new fetch address.
- if_valid  out  1  instruction available to decode/imm-generation stage.
- if_ready  in  1  decode stage accepts instruction.
- if_instr  out  32  instruction word.
- if_pc  out  32  address of if_instr.
- if_pc_plus4  out  32  if_pc + 4, modulo 2^32.

Function
REQ-003 SHALL implement FSM states IDLE, REQ, WAIT, FLUSH, HOLD.
REQ-004 SHALL hold one fetch address register pc and allow at most one outstanding imem request.
REQ-005 IDLE SHALL drive imem_req_valid=0 and go to REQ unconditionally on the next cycle.
REQ-006 REQ SHALL drive imem_req_valid=1 with imem_req_addr=pc. On imem_req_ready=1 and no redirect, it SHALL go to WAIT.
REQ-007 In REQ, imem_req_addr SHALL stay stable while not accepted, except on redirect: pc is replaced and the request is not considered accepted that cycle.
REQ-008 WAIT: on imem_rsp_valid=1 with no redirect, capture if_instr=imem_rsp_data and if_pc=pc, set pc=pc+4 and go to HOLD.
REQ-009 HOLD SHALL assert if_valid=1 with if_instr/if_pc stable. On if_ready=1, go to REQ and drop if_valid the next cycle.
REQ-010 Redirect in REQ or HOLD SHALL load pc=redirect_pc and go to REQ. Any held instruction is discarded; if_valid=0 next cycle.
REQ-011 Redirect in WAIT with imem_rsp_valid=0 SHALL load pc and go to FLUSH. With imem_rsp_valid=1, the response is discarded, pc is loaded, and the FSM goes to REQ.
REQ-012 FLUSH SHALL issue no request and wait for the stale response. On imem_rsp_valid=1, discard it and go to REQ. A redirect in FLUSH updates pc only.
REQ-013 redirect_valid SHALL take priority over if_ready in the same cycle; the instruction is not considered delivered.
REQ-014 pc[1:0] SHALL be forced to 2'b00 on every load, including redirect_pc.
REQ-015 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-016 imem_rsp_valid in IDLE, REQ or HOLD SHALL be ignored.
REQ-017 Latency: request accepted in cycle N, response in N+k, if_valid=1 in N+k+1. Best-case throughput is one instruction per 3 cycles.

Reset
REQ-018 While rst_n=0: state=IDLE, pc=RESET_PC, imem_req_valid=0, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=0, if_pc_plus4=4.
REQ-019 Reset asserted mid-operation SHALL abandon any outstanding request without waiting for its response.

Structure
REQ-020 Package cpu_pkg SHALL hold XLEN=32, the fetch FSM state enum, and the NOP encoding constant.
REQ-021 SHALL be a single module with no sub-modules; if_pc_plus4 is derived combinationally from if_pc.

Verification
REQ-022 Reset release, RESET_PC=0, memory ready with 1-cycle latency -> requests at 0x0, 0x4, 0x8; if_pc sequence 0, 4, 8 with matching if_instr.
REQ-023 if_ready=0 for 5 cycles in HOLD -> if_valid, if_instr and if_pc stable; no new imem request issued.
REQ-024 Redirect to 0x100 while in WAIT, response 2 cycles later -> stale word never reaches if_valid; next request address 0x100.
REQ-025 Redirect to 0x203 concurrent with if_ready=1 in HOLD -> instruction not delivered; next request address 0x200.
REQ-026 pc=0xFFFF_FFFC fetched -> if_pc_plus4=0x0; next request address 0x0.
REQ-027 rst_n pulsed low while in WAIT -> outputs at reset values immediately; first request after release at RESET_PC.
